// File: rtl/tlb_replace_ctrl.sv
// TLB replacement/fill controller: hit decode, victim select
// (lowest invalid line, else tree PLRU) and walker fill sequencing.
//
// Ports:
//   clk, reset    clock, synchronous active-high reset
//   Matches       per-line match vector from the CAM lines
//   TLBAccess     a lookup is performed this cycle
//   TLBFlush      flush all lines
//   FillReq       walker holds a PTE to install (level)
//   FillAck       one-cycle pulse when the fill is done or aborted
//   WriteEnables  one-hot write strobe into the CAM lines
//   VictimIdx     index of the line being written
//   TLBHit        lookup with exactly one match
//   HitIdx        encoded index of the matching line
//   MultiHit      lookup with more than one match
module tlb_replace_ctrl #(
  parameter int TLB_ENTRIES = 8,
  parameter int IDX_BITS    = $clog2(TLB_ENTRIES)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [TLB_ENTRIES-1:0] Matches,
  input  logic                   TLBAccess,
  input  logic                   TLBFlush,
  input  logic                   FillReq,
  output logic                   FillAck,
  output logic [TLB_ENTRIES-1:0] WriteEnables,
  output logic [IDX_BITS-1:0]    VictimIdx,
  output logic                   TLBHit,
  output logic [IDX_BITS-1:0]    HitIdx,
  output logic                   MultiHit
);

  typedef enum logic [1:0] {
    IDLE,
    WRITE,
    ACK
  } state_t;

  state_t                 state;
  logic [TLB_ENTRIES-1:0] valid_vec;
  logic [TLB_ENTRIES-2:0] plru;

  logic [IDX_BITS-1:0] hit_enc;
  logic [IDX_BITS-1:0] free_idx;
  logic [IDX_BITS-1:0] lru_idx;
  logic [IDX_BITS-1:0] victim;
  logic [IDX_BITS-1:0] walk_node;
  int unsigned         match_cnt;

  // Point every node on the path to idx at the opposite half.
  function automatic logic [TLB_ENTRIES-2:0] touch(
    input logic [TLB_ENTRIES-2:0] tree,
    input logic [IDX_BITS-1:0]    idx
  );
    logic [TLB_ENTRIES-2:0] t;
    logic [IDX_BITS-1:0]    node;
    logic                   b;
    t    = tree;
    node = '0;
    for (int l = 0; l < IDX_BITS; l++) begin
      b       = idx[IDX_BITS-1-l];
      t[node] = ~b;
      node    = (node << 1) + IDX_BITS'(1)
              + IDX_BITS'(b);
    end
    return t;
  endfunction

  always_comb begin
    match_cnt = $countones(Matches);
    hit_enc   = '0;
    for (int i = 0; i < TLB_ENTRIES; i++) begin
      if (Matches[i]) hit_enc = hit_enc | IDX_BITS'(i);
    end
  end

  assign TLBHit   = TLBAccess && (match_cnt == 1);
  assign MultiHit = TLBAccess && (match_cnt > 1);
  assign HitIdx   = TLBHit ? hit_enc : '0;

  always_comb begin
    free_idx = '0;
    for (int i = TLB_ENTRIES - 1; i >= 0; i--) begin
      if (!valid_vec[i]) free_idx = IDX_BITS'(i);
    end
    lru_idx   = '0;
    walk_node = '0;
    for (int l = 0; l < IDX_BITS; l++) begin
      lru_idx[IDX_BITS-1-l] = plru[walk_node];
      walk_node = (walk_node << 1) + IDX_BITS'(1)
                + IDX_BITS'(plru[walk_node]);
    end
    victim = (~&valid_vec) ? free_idx : lru_idx;
  end

  // A flush in the write cycle suppresses the strobe.
  assign WriteEnables =
    (state == WRITE && !TLBFlush)
      ? (TLB_ENTRIES'(1) << VictimIdx)
      : '0;

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      valid_vec <= '0;
      plru      <= '0;
      VictimIdx <= '0;
      FillAck   <= 1'b0;
    end else begin
      FillAck <= (state == WRITE);
      unique case (state)
        IDLE: begin
          if (FillReq && !TLBFlush) begin
            VictimIdx <= victim;
            state     <= WRITE;
          end
          if (TLBHit) plru <= touch(plru, HitIdx);
        end
        WRITE: begin
          state <= ACK;
          if (!TLBFlush) begin
            plru                 <= touch(plru, VictimIdx);
            valid_vec[VictimIdx] <= 1'b1;
          end
        end
        ACK: begin
          state <= IDLE;
          if (TLBHit) plru <= touch(plru, HitIdx);
        end
        default: state <= IDLE;
      endcase
      // Flush wins over any same-cycle install or touch.
      if (TLBFlush) begin
        valid_vec <= '0;
        plru      <= '0;
      end
    end
  end

endmodule

// File: tb/tb_tlb_replace_ctrl.sv
// Bench for tlb_replace_ctrl: range-based PLRU/valid model
// compared every cycle, plus directed literal checks.
module tb_tlb_replace_ctrl;

  localparam int N  = 8;
  localparam int IB = 3;

  logic          clk = 1'b0;
  logic          reset;
  logic [N-1:0]  Matches;
  logic          TLBAccess;
  logic          TLBFlush;
  logic          FillReq;
  logic          FillAck;
  logic [N-1:0]  WriteEnables;
  logic [IB-1:0] VictimIdx;
  logic          TLBHit;
  logic [IB-1:0] HitIdx;
  logic          MultiHit;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  tlb_replace_ctrl #(.TLB_ENTRIES(N)) dut (
    .clk(clk),
    .reset(reset),
    .Matches(Matches),
    .TLBAccess(TLBAccess),
    .TLBFlush(TLBFlush),
    .FillReq(FillReq),
    .FillAck(FillAck),
    .WriteEnables(WriteEnables),
    .VictimIdx(VictimIdx),
    .TLBHit(TLBHit),
    .HitIdx(HitIdx),
    .MultiHit(MultiHit)
  );

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=%0h exp=%0h t=%0t",
               name, act, exp, $time);
    end
  endtask

  // Model: phase 0 idle, 1 write, 2 ack.
  int m_phase = 0;
  int m_vic = 0;
  bit m_valid [N];
  bit m_plru [N-1];
  bit m_live = 0;

  function automatic int m_choose();
    int lo, hi, mid, node;
    for (int i = 0; i < N; i++)
      if (!m_valid[i]) return i;
    lo = 0; hi = N; node = 0;
    while (hi - lo > 1) begin
      mid = (lo + hi) / 2;
      if (m_plru[node]) begin
        lo = mid; node = 2 * node + 2;
      end else begin
        hi = mid; node = 2 * node + 1;
      end
    end
    return lo;
  endfunction

  function automatic void m_touch(input int i);
    int lo, hi, mid, node;
    lo = 0; hi = N; node = 0;
    while (hi - lo > 1) begin
      mid = (lo + hi) / 2;
      if (i < mid) begin
        m_plru[node] = 1'b1;
        hi = mid; node = 2 * node + 1;
      end else begin
        m_plru[node] = 1'b0;
        lo = mid; node = 2 * node + 2;
      end
    end
  endfunction

  function automatic int hit_line();
    int h;
    h = 0;
    for (int i = 0; i < N; i++)
      if (Matches[i]) h = i;
    return h;
  endfunction

  function automatic void m_clear();
    for (int i = 0; i < N; i++) m_valid[i] = 1'b0;
    for (int i = 0; i < N - 1; i++) m_plru[i] = 1'b0;
  endfunction

  always @(posedge clk) begin : model
    bit hit;
    hit = TLBAccess && ($countones(Matches) == 1);
    if (reset) begin
      m_phase = 0;
      m_vic = 0;
      m_clear();
    end else begin
      case (m_phase)
        0: begin
          if (FillReq && !TLBFlush) begin
            m_vic = m_choose();
            m_phase = 1;
          end
          if (hit) m_touch(hit_line());
        end
        1: begin
          if (!TLBFlush) begin
            m_touch(m_vic);
            m_valid[m_vic] = 1'b1;
          end
          m_phase = 2;
        end
        default: begin
          if (hit) m_touch(hit_line());
          m_phase = 0;
        end
      endcase
      if (TLBFlush) m_clear();
    end
    m_live = 1'b1;
  end

  always @(negedge clk) begin : compare
    int hc;
    logic [N-1:0] we;
    if (m_live) begin
      hc = $countones(Matches);
      we = (m_phase == 1 && !TLBFlush)
           ? (N'(1) << m_vic) : '0;
      chk("m_we", 32'(WriteEnables), 32'(we));
      chk("m_ack", 32'(FillAck), 32'(m_phase == 2));
      chk("m_vic", 32'(VictimIdx), 32'(m_vic));
      chk("m_hit", 32'(TLBHit),
          32'(TLBAccess && hc == 1));
      chk("m_multi", 32'(MultiHit),
          32'(TLBAccess && hc > 1));
      chk("m_hidx", 32'(HitIdx),
          (TLBAccess && hc == 1) ? 32'(hit_line()) : 0);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One fill; exp < 0 leaves the victim to the model.
  task automatic fill(input int exp, input bit fl,
                      input bit hit0);
    FillReq = 1'b1;
    step();
    if (fl) TLBFlush = 1'b1;
    #1;
    if (exp >= 0) begin
      chk("victim", 32'(VictimIdx), 32'(exp));
      chk("we_onehot", 32'(WriteEnables),
          fl ? 0 : 32'(1) << exp);
    end
    step();
    TLBFlush = 1'b0;
    if (hit0) begin
      TLBAccess = 1'b1;
      Matches = 8'h01;
    end
    #1;
    chk("ack", 32'(FillAck), 1);
    chk("we_ack", 32'(WriteEnables), 0);
    step();
    FillReq = 1'b0;
    TLBAccess = 1'b0;
    Matches = '0;
    #1;
    chk("ack_low", 32'(FillAck), 0);
  endtask

  task automatic lookup(input logic [N-1:0] m);
    TLBAccess = 1'b1;
    Matches = m;
    #1;
  endtask

  initial begin
    reset = 1'b1;
    Matches = '0;
    TLBAccess = 1'b0;
    TLBFlush = 1'b0;
    FillReq = 1'b0;
    repeat (2) step();
    reset = 1'b0;
    #1;
    chk("rst_we", 32'(WriteEnables), 0);
    chk("rst_ack", 32'(FillAck), 0);
    chk("rst_vic", 32'(VictimIdx), 0);

    // Cold fills take lines in index order.
    for (int i = 0; i < N; i++) fill(i, 1'b0, 1'b0);

    // Hits on 0 then 4 steer the PLRU to line 2.
    lookup(8'h01);
    chk("hit0", 32'(TLBHit), 1);
    chk("hidx0", 32'(HitIdx), 0);
    step();
    lookup(8'h10);
    chk("hit4", 32'(TLBHit), 1);
    chk("hidx4", 32'(HitIdx), 4);
    step();
    TLBAccess = 1'b0;
    Matches = '0;
    fill(2, 1'b0, 1'b0);

    // Multi-hit flags an error and leaves the PLRU alone.
    lookup(8'b0001_0010);
    chk("multi", 32'(MultiHit), 1);
    chk("multi_hit", 32'(TLBHit), 0);
    chk("multi_hidx", 32'(HitIdx), 0);
    step();
    TLBAccess = 1'b0;
    Matches = '0;
    fill(6, 1'b0, 1'b0);

    // Flush during the write aborts the install.
    fill(1, 1'b1, 1'b0);
    fill(0, 1'b0, 1'b0);

    // Reset in the write cycle abandons the fill.
    FillReq = 1'b1;
    step();
    reset = 1'b1;
    FillReq = 1'b0;
    step();
    chk("rst_mid_we", 32'(WriteEnables), 0);
    chk("rst_mid_ack", 32'(FillAck), 0);
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("rst_no_ack", 32'(FillAck), 0);
    end

    // Fill everything, flush with a pending request.
    for (int i = 0; i < N; i++) fill(i, 1'b0, 1'b0);
    FillReq = 1'b1;
    TLBFlush = 1'b1;
    step();
    TLBFlush = 1'b0;
    #1;
    chk("flush_hold_we", 32'(WriteEnables), 0);
    fill(0, 1'b0, 1'b1);
    for (int i = 1; i < N; i++) fill(i, 1'b0, 1'b0);
    fill(0, 1'b0, 1'b0);

    repeat (3) step();
    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
